tt_um_dco: RTL and testbench

- Fully synthesizable digitally controlled oscillator built as a phase-accumulator NCO: an 8-bit frequency code on ui_in sets the output frequency.
- Top-level user tile: dedicated inputs carry the code, dedicated outputs carry the oscillator square wave plus status and monitor signals, and the bidirectional pins are unused.
- Output frequency = f_clk * code / 2^ACC_W.

---
 rtl/tt_um_dco.sv | 83 ++++++++
 tb/tb_tt_um_dco.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_dco.sv
// tt_um_dco -- phase-accumulator digitally controlled oscillator tile.
// The 8-bit code on ui_in is added to an ACC_W-bit phase accumulator each
// enabled clock; the accumulator MSB is the square-wave output, so
// f_out = f_clk * code / 2^ACC_W.
// Optional build macro DCO_SYNC_UPDATE_EN: the code is staged in a pending
// register and only reaches the accumulator at a period boundary (wrap) or
// while stopped (code 0), giving glitch-free retunes.
module tt_um_dco #(
    parameter int ACC_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [7:0]       code_reg;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             wrap_r;
    logic             dco_q;
    logic [3:0]       edge_cnt;
    logic             dco_out;
    logic             unused_uio;

`ifdef DCO_SYNC_UPDATE_EN
    logic [7:0] pend_reg;
    logic       load_code;

    // Retune only when the phase has just wrapped or the oscillator is stopped.
    assign load_code = sum[ACC_W] || (code_reg == 8'd0);
`endif

    // Next phase with the carry kept as the top bit; the carry is the wrap event.
    always_comb begin
        sum = {1'b0, acc} + (ACC_W + 1)'(code_reg);
    end

    // Oscillator state: code sampling, phase accumulation, wrap pulse, edge counter.
    // NOTE: every register here uses <= so all of them see pre-edge values; a
    // blocking = would let dco_q capture the new acc MSB and hide rising edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_reg <= 8'd0;
            acc      <= '0;
            wrap_r   <= 1'b0;
            dco_q    <= 1'b0;
            edge_cnt <= 4'd0;
`ifdef DCO_SYNC_UPDATE_EN
            pend_reg <= 8'd0;
`endif
        end else if (ena) begin
`ifdef DCO_SYNC_UPDATE_EN
            pend_reg <= ui_in;
            if (load_code) begin
                code_reg <= pend_reg;
            end
`else
            code_reg <= ui_in;
`endif
            acc    <= sum[ACC_W-1:0];
            wrap_r <= sum[ACC_W];
            dco_q  <= dco_out;
            if (dco_out && !dco_q) begin
                edge_cnt <= edge_cnt + 4'd1;
            end
        end else begin
            // Disabled: everything holds except the wrap pulse, which must not stick high.
            wrap_r <= 1'b0;
        end
    end

    assign dco_out    = acc[ACC_W-1];
    assign uo_out     = {edge_cnt, (code_reg == 8'd0), wrap_r, ~dco_out, dco_out};
    assign uio_out    = 8'd0;
    assign uio_oe     = 8'd0;
    assign unused_uio = &{1'b0, uio_in};

endmodule

// File: tb/tb_tt_um_dco.sv
// tb_tt_um_dco -- self-checking bench for tt_um_dco (ACC_W = 10, 20 ns clock).
// A phase/increment reference model predicts uo_out after every clock; directed
// measurements check periods, duty, wrap counts and edge counting.
module tb_tt_um_dco;

    localparam int ACC_W = 10;
    localparam int FULL  = 1 << ACC_W;
    localparam int HALF  = FULL / 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b1;
    logic [7:0] ui_in = 8'd0;
    logic [7:0] uio_in = 8'd0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests = 0;
    int fails = 0;

    // Reference model: phase in [0, FULL), current increment, staged code,
    // wrap flag of the last edge, rising-edge count and the delayed output level.
    int m_phase, m_code, m_pend, m_cnt;
    bit m_wrap, m_prev;

    // Measurements taken from the DUT output pins.
    int cyc, last_rise, prev_rise, high_len, wraps, wraps_period, wrap_total;
    int rises_total, rises_before, high_seen;
    bit last_lvl;

    tt_um_dco #(.ACC_W(ACC_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0; m_code = 0; m_pend = 0; m_cnt = 0; m_wrap = 0; m_prev = 0;
    endfunction

    function automatic void meas_reset();
        cyc = 0; last_rise = 0; prev_rise = 0; high_len = 0; wraps = 0;
        wraps_period = 0; wrap_total = 0; rises_total = 0; rises_before = 0;
        high_seen = 0; last_lvl = 0;
    endfunction

    // One enabled clock in the model: phase advances by the current code,
    // a rise of the output level bumps the counter one clock later.
    function automatic void model_edge(input bit en, input int ui);
        bit lvl;
        int nxt;
        if (!en) begin
            m_wrap = 0;
            return;
        end
        lvl = (m_phase >= HALF);
        if (lvl && !m_prev) m_cnt = (m_cnt + 1) % 16;
        m_prev = lvl;
        nxt    = m_phase + m_code;
        m_wrap = (nxt >= FULL);
`ifdef DCO_SYNC_UPDATE_EN
        if (m_wrap || m_code == 0) m_code = m_pend;
        m_pend = ui;
`else
        m_code = ui;
`endif
        m_phase = nxt % FULL;
    endfunction

    function automatic logic [7:0] model_out();
        logic [3:0] c;
        bit lvl;
        c   = 4'(m_cnt);
        lvl = (m_phase >= HALF);
        return {c, (m_code == 0), m_wrap, !lvl, lvl};
    endfunction

    // Advance one clock, compare against the model, then update pin measurements.
    task automatic step(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(ena, ui_in);
        #1;
        check(tag, {8'd0, uo_out}, {8'd0, model_out()});
        cyc++;
        rises_before = rises_total;
        if (uo_out[2]) begin
            wraps++;
            wrap_total++;
        end
        if (uo_out[0]) high_seen++;
        if (uo_out[0] && !last_lvl) begin
            prev_rise    = last_rise;
            last_rise    = cyc;
            wraps_period = wraps;
            wraps        = 0;
            rises_total++;
        end
        if (!uo_out[0] && last_lvl) high_len = cyc - last_rise;
        last_lvl = uo_out[0];
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Assert reset in the middle of a clock period and check it clears at once.
    task automatic async_reset(input int hold);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        meas_reset();
        check("reset_async", {8'd0, uo_out}, 16'h000A);
        for (int i = 0; i < hold; i++) begin
            ui_in = 8'($urandom);
            step("reset_hold");
        end
        #4 rst_n = 1'b1;
    endtask

    logic [7:0] frozen;
    int         n;

    initial begin
        model_reset();
        meas_reset();

        // Reset with clocks running and random codes on the inputs.
        for (int i = 0; i < 5; i++) begin
            ui_in = 8'($urandom);
            step("reset_run");
        end
        check("uio_out", {8'd0, uio_out}, 16'd0);
        check("uio_oe", {8'd0, uio_oe}, 16'd0);
        async_reset(3);

        // Code 0: nothing moves.
        ui_in = 8'd0;
        run("code0", 4000);
        check("code0_wraps", 16'(wrap_total), 16'd0);
        check("code0_high", 16'(high_seen), 16'd0);
        check("code0_flag", {15'd0, uo_out[3]}, 16'd1);

        // Code 1: 1024-clock period, 512 high, one wrap per period.
        ui_in = 8'd1;
        run("code1", 2100);
        check("code1_period", 16'(last_rise - prev_rise), 16'd1024);
        check("code1_high", 16'(high_len), 16'd512);
        check("code1_wraps", 16'(wraps_period), 16'd1);

        // Power-of-two sweep: period FULL/code, exact 50% duty.
        for (int k = 1; k < 8; k++) begin
            ui_in = 8'(1 << k);
            n = 3 * (FULL >> k) + 4;
            if (n < 200) n = 200;
            run("sweep", n);
            check($sformatf("sweep%0d_period", 1 << k), 16'(last_rise - prev_rise), 16'(FULL >> k));
            check($sformatf("sweep%0d_high", 1 << k), 16'(high_len), 16'(HALF >> k));
            check($sformatf("sweep%0d_edges", 1 << k), {12'd0, uo_out[7:4]}, 16'(rises_before % 16));
        end

        // Enable low for 50 clocks at code 8: state frozen, wrap forced low.
        ui_in = 8'd8;
        run("ena_pre", 100);
        ena = 1'b0;
        step("ena_off");
        frozen = model_out();
        for (int i = 0; i < 49; i++) begin
            ui_in = 8'($urandom);
            step("ena_off");
            check("ena_frozen", {8'd0, uo_out}, {8'd0, frozen});
        end
        check("ena_wrap_low", {15'd0, uo_out[2]}, 16'd0);
        ui_in = 8'd8;
        ena   = 1'b1;
        run("ena_resume", 300);
        check("ena_period", 16'(last_rise - prev_rise), 16'd128);

        // Retune 3 -> 128 mid-period, continuous phase.
        async_reset(2);
        ui_in = 8'd3;
        run("retune_slow", 300);
        ui_in = 8'd128;
        run("retune_fast", 100);
        check("retune_period", 16'(last_rise - prev_rise), 16'd8);
        check("retune_high", 16'(high_len), 16'd4);

        // Randomized traffic: code changes, enable gaps, occasional reset.
        ui_in = 8'($urandom);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(29, 0) == 0) ui_in = 8'($urandom);
            ena = ($urandom_range(9, 0) != 0);
            if ($urandom_range(499, 0) == 0) async_reset(1);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
